// File: rtl/sprite_compositor.sv
// sprite_compositor: shadow/active sprite geometry banks committed on the falling
// edge of vs, a 3-stage pixel pipeline (address gen -> external ROM -> composite)
// and per-frame collision flags against sprite 0.
module sprite_compositor #(
  parameter int          SPR_NUM = 8,
  parameter int          ADDR_W  = 14,
  parameter logic [11:0] KEY     = 12'h428,
  parameter int          IDX_W   = $clog2(SPR_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [IDX_W-1:0]          cfg_idx,
  input  logic [9:0]                cfg_x,
  input  logic [8:0]                cfg_y,
  input  logic [6:0]                cfg_w,
  input  logic [6:0]                cfg_h,
  input  logic                      cfg_en,
  input  logic                      vs,
  input  logic [9:0]                col_addr,
  input  logic [8:0]                row_addr,
  input  logic                      pix_valid,
  output logic [SPR_NUM*ADDR_W-1:0] spr_addr,
  input  logic [SPR_NUM*12-1:0]     spr_data,
  input  logic [11:0]               bg_data,
  output logic [11:0]               vga_data,
  output logic                      vga_valid,
  output logic [SPR_NUM-1:0]        coll_flags,
  output logic                      frame_commit
);

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [6:0] w;
    logic [6:0] h;
    logic       en;
  } geom_t;

  geom_t              shadow_q [SPR_NUM];
  geom_t              shadow_d [SPR_NUM];
  geom_t              active_q [SPR_NUM];
  geom_t              active_d [SPR_NUM];
  logic               vs_prev_q, vs_prev_d;
  logic               commit;
  logic               frame_commit_q, frame_commit_d;

  addr_t              addr_q [SPR_NUM];
  addr_t              addr_d [SPR_NUM];
  logic [SPR_NUM-1:0] inbox1_q, inbox1_d;
  logic               valid1_q, valid1_d;
  logic [SPR_NUM-1:0] inbox2_q, inbox2_d;
  logic               valid2_q, valid2_d;
  logic [11:0]        vga_data_q, vga_data_d;
  logic               vga_valid_q, vga_valid_d;

  logic [SPR_NUM-1:0] opaque;
  logic [SPR_NUM-1:0] hit_now;
  logic [SPR_NUM-1:0] acc_q, acc_d;
  logic [SPR_NUM-1:0] coll_q, coll_d;

  // Commit edge detect and shadow/active bank update. The commit copies the
  // pre-write shadow contents, so a same-cycle write waits for the next frame.
  always_comb begin
    commit         = vs_prev_q & ~vs;
    vs_prev_d      = vs;
    frame_commit_d = commit;
    shadow_d       = shadow_q;
    active_d       = active_q;
    if (commit) begin
      active_d = shadow_q;
    end
    if (cfg_we) begin
      shadow_d[cfg_idx].x  = cfg_x;
      shadow_d[cfg_idx].y  = cfg_y;
      shadow_d[cfg_idx].w  = cfg_w;
      shadow_d[cfg_idx].h  = cfg_h;
      shadow_d[cfg_idx].en = cfg_en;
    end
  end

  // Stage 1: in-box test against the active bank and ROM address generation.
  // Box ends are widened by one bit so boxes past the screen edge clip instead of wrapping.
  always_comb begin : stage1_comb
    logic [10:0] x_end;
    logic [9:0]  y_end;
    logic [9:0]  dx;
    logic [8:0]  dy;
    logic        in_box;
    valid1_d = pix_valid;
    inbox1_d = '0;
    for (int unsigned i = 0; i < SPR_NUM; i++) begin
      x_end  = {1'b0, active_q[i].x} + {4'b0, active_q[i].w};
      y_end  = {1'b0, active_q[i].y} + {3'b0, active_q[i].h};
      dx     = col_addr - active_q[i].x;
      dy     = row_addr - active_q[i].y;
      in_box = pix_valid & active_q[i].en &
               (active_q[i].w != '0) & (active_q[i].h != '0) &
               (col_addr >= active_q[i].x) & ({1'b0, col_addr} < x_end) &
               (row_addr >= active_q[i].y) & ({1'b0, row_addr} < y_end);
      inbox1_d[i] = in_box;
      addr_d[i]   = in_box ? (addr_t'(dy) * addr_t'(active_q[i].w) + addr_t'(dx)) : '0;
    end
  end

  // Stages 2 and 3: delay the sideband past the ROM, then composite by priority
  // and accumulate collisions against sprite 0.
  always_comb begin
    inbox2_d   = inbox1_q;
    valid2_d   = valid1_q;
    vga_data_d = bg_data;
    opaque     = '0;
    hit_now    = '0;
    for (int unsigned i = 0; i < SPR_NUM; i++) begin
      if (inbox2_q[i] && (spr_data[i*12 +: 12] != KEY)) begin
        opaque[i]  = 1'b1;
        vga_data_d = spr_data[i*12 +: 12];
      end
    end
    for (int unsigned i = 1; i < SPR_NUM; i++) begin
      hit_now[i] = valid2_q & opaque[0] & opaque[i];
    end
    if (!valid2_q) begin
      vga_data_d = '0;
    end
    vga_valid_d = valid2_q;
    if (commit) begin
      coll_d = acc_q | hit_now;
      acc_d  = '0;
    end else begin
      coll_d = coll_q;
      acc_d  = acc_q | hit_now;
    end
  end

  // State registers with synchronous reset; reset also flushes the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q       <= '{default: '0};
      active_q       <= '{default: '0};
      vs_prev_q      <= 1'b1;
      frame_commit_q <= 1'b0;
      addr_q         <= '{default: '0};
      inbox1_q       <= '0;
      valid1_q       <= 1'b0;
      inbox2_q       <= '0;
      valid2_q       <= 1'b0;
      vga_data_q     <= '0;
      vga_valid_q    <= 1'b0;
      acc_q          <= '0;
      coll_q         <= '0;
    end else begin
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      vs_prev_q      <= vs_prev_d;
      frame_commit_q <= frame_commit_d;
      addr_q         <= addr_d;
      inbox1_q       <= inbox1_d;
      valid1_q       <= valid1_d;
      inbox2_q       <= inbox2_d;
      valid2_q       <= valid2_d;
      vga_data_q     <= vga_data_d;
      vga_valid_q    <= vga_valid_d;
      acc_q          <= acc_d;
      coll_q         <= coll_d;
    end
  end

  for (genvar g = 0; g < SPR_NUM; g++) begin : g_addr_out
    assign spr_addr[g*ADDR_W +: ADDR_W] = addr_q[g];
  end

  assign vga_data     = vga_data_q;
  assign vga_valid    = vga_valid_q;
  assign coll_flags   = coll_q;
  assign frame_commit = frame_commit_q;

endmodule
